// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign encodings,
// the controller state type and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Undefined encodings fall through to a full-word access.
  function automatic lsu_size_t size_of(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: size_of = SZ_B;
      F3_LH, F3_LHU: size_of = SZ_H;
      default:       size_of = SZ_W;
    endcase
  endfunction

  // Halves need an even address, words a word-aligned one.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (size_of(funct3))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Store side replicates data across lanes and builds byte strobes; load side
// picks the addressed byte/half and extends it. Low address bits that do not
// fit the access size are ignored, so a misaligned half uses addr_lo[1] only
// and a misaligned word behaves as aligned.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  function automatic logic signed [31:0] ext8(input logic [7:0] b, input logic sgn);
    ext8 = sgn ? {{24{b[7]}}, b} : {24'd0, b};
  endfunction

  function automatic logic signed [31:0] ext16(input logic [15:0] h, input logic sgn);
    ext16 = sgn ? {{16{h[15]}}, h} : {16'd0, h};
  endfunction

  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic        sgn;

  assign byte_sh = load_word >> {addr_lo, 3'b000};
  assign half_sh = load_word >> {addr_lo[1], 4'b0000};
  assign sgn     = ~funct3[2];

  // store path: lane replication and strobes (no strobes for loads)
  always_comb begin
    wdata = store_data;
    wstrb = 4'b1111;
    case (size_of(funct3))
      SZ_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
    if (!is_store)
      wstrb = 4'b0000;
  end

  // load path: lane select then sign/zero extension
  always_comb begin
    load_data = load_word;
    case (size_of(funct3))
      SZ_B:    load_data = ext8(byte_sh[7:0], sgn);
      SZ_H:    load_data = ext16(half_sh[15:0], sgn);
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time from execute, runs a
// req/gnt/rvalid memory handshake and returns one extended response pulse.
// Build option: LSU_MISALIGN_TRAP_EN - misaligned H/W accesses answer
// immediately with rsp_err=1 and never reach memory. When undefined the
// offending low address bits are ignored and rsp_err stays 0.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  lsu_state_t state, state_nxt;

  logic              we_p1;
  logic [2:0]        f3_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [XLEN-1:0]   wdata_p1;
  logic [XLEN-1:0]   rdata_p2;
  logic              accept;
  logic              trap;
  logic [XLEN-1:0]   lane_wdata;
  logic [3:0]        lane_wstrb;
  logic [XLEN-1:0]   load_data;

  assign accept = req_valid && req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_p1;

  assign trap = is_misaligned(req_funct3, req_addr[1:0]);

  // error flag for the pending response, decided at accept
  always_ff @(posedge clk) begin
    if (reset)
      err_p1 <= 1'b0;
    else if (accept)
      err_p1 <= trap;
  end

  assign rsp_err = (state == RESP) && err_p1;
`else
  assign trap    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (f3_p1),
    .addr_lo    (addr_p1[1:0]),
    .is_store   (we_p1),
    .store_data (wdata_p1),
    .load_word  (mem_rdata),
    .wdata      (lane_wdata),
    .wstrb      (lane_wstrb),
    .load_data  (load_data)
  );

  // state register; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // stage p1: request fields latched at accept; stage p2: response data
  always_ff @(posedge clk) begin
    if (reset) begin
      we_p1    <= 1'b0;
      f3_p1    <= 3'b000;
      addr_p1  <= '0;
      wdata_p1 <= '0;
      rdata_p2 <= '0;
    end else begin
      if (accept) begin
        we_p1    <= req_we;
        f3_p1    <= req_funct3;
        addr_p1  <= req_addr;
        wdata_p1 <= req_wdata;
      end
      if (accept && trap)
        rdata_p2 <= '0;
      else if (state == WAIT && mem_rvalid)
        rdata_p2 <= we_p1 ? '0 : load_data;
    end
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept)
          state_nxt = trap ? RESP : REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_gnt)
          state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)
          state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_we    = mem_req && we_p1;
  assign mem_addr  = {addr_p1[ADDR_W-1:2], 2'b00};
  assign mem_wdata = lane_wdata;
  assign mem_wstrb = mem_req ? lane_wstrb : 4'b0000;
  assign rsp_rdata = rdata_p2;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a transaction-level reference model.
module tb_load_store_unit;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int nvec = 0;
  int nerr = 0;

  logic        chk_en = 1'b0;
  logic        exp_req_ready, exp_mem_req, exp_mem_we, exp_rsp_valid, exp_rsp_err;
  logic [31:0] exp_mem_addr, exp_mem_wdata, exp_rsp_rdata;
  logic [3:0]  exp_mem_wstrb;

  load_store_unit dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f, input logic [31:0] a);
    return (a % m_size(f)) != 0;
  endfunction

  function automatic logic [3:0] m_wstrb(input logic we, input logic [2:0] f, input logic [31:0] a);
    int n;
    int off;
    n = m_size(f);
    if (!we) return 4'b0000;
    if (n == 4) return 4'b1111;
    off = (n == 2) ? int'(a & 2) : int'(a & 3);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
    case (m_size(f))
      1:       return d[7:0] * 32'h01010101;
      2:       return d[15:0] * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
    int     n;
    longint off, v;
    n = m_size(f);
    if (n == 4) return w;
    off = (n == 2) ? longint'(a & 2) : longint'(a & 3);
    v   = (longint'(w) >> (8 * off)) & ((64'sd1 << (8 * n)) - 1);
    if (f[2] == 1'b0 && v >= (64'sd1 << (8 * n - 1)))
      v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // every-cycle compare against the model expectations
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("req_ready", req_ready, exp_req_ready);
      chk1("mem_req", mem_req, exp_mem_req);
      chk1("rsp_valid", rsp_valid, exp_rsp_valid);
      if (exp_mem_req) begin
        chk32("mem_addr", mem_addr, exp_mem_addr);
        chk1("mem_we", mem_we, exp_mem_we);
        chk32("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_mem_wstrb});
        if (exp_mem_we)
          chk32("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_rsp_valid) begin
        chk32("rsp_rdata", rsp_rdata, exp_rsp_rdata);
        chk1("rsp_err", rsp_err, exp_rsp_err);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_req_ready = 1'b1;
    exp_mem_req   = 1'b0;
    exp_rsp_valid = 1'b0;
  endtask

  // One request: accept, optional gnt stall, rvalid delay (>=1), response.
  // lm bits select literal checks: 0 addr, 1 wstrb, 2 wdata, 3 rsp_rdata.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd, input int gd, input int rvd,
                     input logic [3:0] lm, input logic [31:0] l_addr, input logic [3:0] l_strb,
                     input logic [31:0] l_wdata, input logic [31:0] l_rsp);
    bit mis;
    mis = TRAP && m_misaligned(f3, a);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    set_idle_exp();
    step();
    // scramble request inputs; the DUT must use its latched copy
    req_valid  = 1'b0;
    req_we     = ~we;
    req_funct3 = ~f3;
    req_addr   = ~a;
    req_wdata  = ~d;
    exp_req_ready = 1'b0;
    if (mis) begin
      exp_rsp_valid = 1'b1;
      exp_rsp_rdata = 32'h0;
      exp_rsp_err   = 1'b1;
      step();
    end else begin
      exp_mem_req   = 1'b1;
      exp_mem_addr  = a & ~32'h3;
      exp_mem_we    = we;
      exp_mem_wstrb = m_wstrb(we, f3, a);
      exp_mem_wdata = m_wdata(f3, d);
      for (int i = 0; i <= gd; i++) begin
        mem_gnt = (i == gd);
        if (i == 0 && lm != 4'b0000) begin
          @(negedge clk);
          if (lm[0]) chk32("lit_mem_addr", mem_addr, l_addr);
          if (lm[1]) chk32("lit_mem_wstrb", {28'd0, mem_wstrb}, {28'd0, l_strb});
          if (lm[2]) chk32("lit_mem_wdata", mem_wdata, l_wdata);
        end
        step();
      end
      mem_gnt     = 1'b0;
      exp_mem_req = 1'b0;
      for (int i = 0; i < rvd; i++) begin
        mem_rvalid = (i == rvd - 1);
        mem_rdata  = (i == rvd - 1) ? rd : ~rd;
        step();
      end
      mem_rvalid    = 1'b0;
      mem_rdata     = 32'h0;
      exp_rsp_valid = 1'b1;
      exp_rsp_rdata = we ? 32'h0 : m_load(f3, a, rd);
      exp_rsp_err   = 1'b0;
      if (lm[3]) begin
        @(negedge clk);
        chk32("lit_rsp_rdata", rsp_rdata, l_rsp);
      end
      step();
    end
    set_idle_exp();
  endtask

  // stimulus
  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    set_idle_exp();
    exp_rsp_err = 1'b0;
    step();
    step();
    @(negedge clk);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'h0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    step();
    reset  = 1'b0;
    chk_en = 1'b1;
    step();

    // SW, minimum latency
    txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1, 4'b1011, 32'h100, 4'b1111, 32'h0, 32'h0);
    // SB to lane 3
    txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1, 4'b0111, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
    // LB / LBU at lane 2
    txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h12F45678, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'hFFFFFFF4);
    txn(1'b0, 3'b100, 32'h102, 32'h0, 32'h12F45678, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'h000000F4);
    // LH / LHU upper half
    txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h80001234, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'hFFFF8000);
    txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h80001234, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'h00008000);
    // SW with gnt withheld 3 cycles and slow rvalid
    txn(1'b1, 3'b010, 32'h204, 32'h01234567, 32'h0, 3, 2, 4'b0011, 32'h204, 4'b1111, 32'h0, 32'h0);
    // SH upper half
    txn(1'b1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0, 1, 1, 4'b0111, 32'h104, 4'b1100, 32'hBEEFBEEF, 32'h0);
    // LB sign bit in lane 1
    txn(1'b0, 3'b000, 32'h101, 32'h0, 32'h00008000, 0, 3, 4'b1000, 32'h0, 4'h0, 32'h0, 32'hFFFFFF80);
    // undefined funct3 acts as a word load
    txn(1'b0, 3'b011, 32'h108, 32'h0, 32'h89ABCDEF, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'h89ABCDEF);
    // misaligned LW and LH
    if (TRAP) begin
      txn(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
      txn(1'b0, 3'b001, 32'h103, 32'h0, 32'h7FFF0000, 0, 1, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0);
    end else begin
      txn(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, 4'b1001, 32'h100, 4'h0, 32'h0, 32'hCAFEF00D);
      txn(1'b0, 3'b001, 32'h103, 32'h0, 32'h7FFF0000, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'h00007FFF);
    end

    // reset while waiting for rvalid
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h300;
    set_idle_exp();
    step();
    req_valid     = 1'b0;
    exp_req_ready = 1'b0;
    exp_mem_req   = 1'b1;
    exp_mem_addr  = 32'h300;
    exp_mem_we    = 1'b0;
    exp_mem_wstrb = 4'b0000;
    mem_gnt       = 1'b1;
    step();
    mem_gnt     = 1'b0;
    exp_mem_req = 1'b0;
    reset       = 1'b1;
    step();
    reset = 1'b0;
    set_idle_exp();
    @(negedge clk);
    chk32("rst_wait_mem_addr", mem_addr, 32'h0);
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55AA55AA;
    step();
    mem_rvalid = 1'b0;
    step();

    // stray gnt/rvalid while idle
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    step();
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    step();

    // still functional afterwards
    txn(1'b0, 3'b101, 32'h2, 32'h0, 32'hFEDC0000, 0, 1, 4'b1000, 32'h0, 4'h0, 32'h0, 32'h0000FEDC);
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", nvec);
    $fatal(1);
  end

endmodule
